// File: rtl/rs_two_wide_pkg.sv
// Shared types for the two-wide reservation station: dispatch, CDB and issue
// packets plus the operand wakeup helper used by every entry.
package rs_two_wide_pkg;

  localparam int PRF_BITS = 6;
  localparam int RS_DEPTH = 8;
  localparam int XLEN     = 64;

  typedef enum logic [2:0] {
    OP_ALU = 3'd0,
    OP_MUL = 3'd1,
    OP_MEM = 3'd2,
    OP_BR  = 3'd3,
    OP_FP  = 3'd4
  } op_type_t;

  typedef struct packed {
    logic                dispatch;
    logic                thread_ID;
    op_type_t            op_type;
    logic [4:0]          operation;
    logic                op1_ready;
    logic [XLEN-1:0]     op1_value;
    logic [PRF_BITS-1:0] op1_PRF_index;
    logic                op2_ready;
    logic [XLEN-1:0]     op2_value;
    logic [PRF_BITS-1:0] op2_PRF_index;
    logic [PRF_BITS-1:0] dest_PRF_index;
    logic [XLEN-1:0]     next_pc;
    logic [XLEN-1:0]     branch_target_addr;
  } DISPATCH_RS;

  typedef struct packed {
    logic                valid;
    logic [PRF_BITS-1:0] PRN;
    logic [XLEN-1:0]     value;
  } CDB_PACKET;

  typedef struct packed {
    logic                valid;
    logic                thread_ID;
    op_type_t            op_type;
    logic [4:0]          operation;
    logic [XLEN-1:0]     op1_value;
    logic [XLEN-1:0]     op2_value;
    logic [PRF_BITS-1:0] dest_PRF_index;
    logic [XLEN-1:0]     next_pc;
    logic [XLEN-1:0]     branch_target_addr;
  } RS_ISSUE;

  // Capture any pending operand broadcast on a CDB; cdb0 wins a double match.
  function automatic DISPATCH_RS rs_wake(input DISPATCH_RS p,
                                         input CDB_PACKET c0,
                                         input CDB_PACKET c1);
    DISPATCH_RS r;
    r = p;
    if (!p.op1_ready) begin
      if (c0.valid && c0.PRN == p.op1_PRF_index) begin
        r.op1_ready = 1'b1;
        r.op1_value = c0.value;
      end else if (c1.valid && c1.PRN == p.op1_PRF_index) begin
        r.op1_ready = 1'b1;
        r.op1_value = c1.value;
      end
    end
    if (!p.op2_ready) begin
      if (c0.valid && c0.PRN == p.op2_PRF_index) begin
        r.op2_ready = 1'b1;
        r.op2_value = c0.value;
      end else if (c1.valid && c1.PRN == p.op2_PRF_index) begin
        r.op2_ready = 1'b1;
        r.op2_value = c1.value;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_two_wide_if.sv
// Dispatch/CDB/issue bundle between the dispatch stage, the RS and the FUs.
interface rs_two_wide_if;
  import rs_two_wide_pkg::*;

  DISPATCH_RS disp_RS_0;
  DISPATCH_RS disp_RS_1;
  CDB_PACKET  cdb_0;
  CDB_PACKET  cdb_1;
  logic       mispredict_ROB_0;
  logic       mispredict_ROB_1;
  logic       issue_stall;
  RS_ISSUE    issue_out;
  logic       RS_full;
  logic       RS_almost_full;

  modport master (
    output disp_RS_0, disp_RS_1, cdb_0, cdb_1,
           mispredict_ROB_0, mispredict_ROB_1, issue_stall,
    input  issue_out, RS_full, RS_almost_full
  );

  modport slave (
    input  disp_RS_0, disp_RS_1, cdb_0, cdb_1,
           mispredict_ROB_0, mispredict_ROB_1, issue_stall,
    output issue_out, RS_full, RS_almost_full
  );
endinterface

// File: rtl/rs_two_wide_entry.sv
// One reservation-station slot: write port, CDB wakeup, thread squash, issue free.
// The stored packet's dispatch bit doubles as the entry valid bit.
module rs_entry
  import rs_two_wide_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en_i,
  input  DISPATCH_RS wr_pkt_i,
  input  CDB_PACKET  cdb0_i,
  input  CDB_PACKET  cdb1_i,
  input  logic [1:0] squash_i,
  input  logic       issue_i,
  output logic       vld_o,
  output logic       vld_nxt_o,
  output RS_ISSUE    iss_o
);

  DISPATCH_RS ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (wr_en_i) begin
      ent_d          = rs_wake(wr_pkt_i, cdb0_i, cdb1_i);
      ent_d.dispatch = 1'b1;
    end else if (ent_q.dispatch) begin
      ent_d = rs_wake(ent_q, cdb0_i, cdb1_i);
    end
    if (issue_i)
      ent_d.dispatch = 1'b0;
    if (squash_i[ent_d.thread_ID])
      ent_d.dispatch = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign vld_o     = ent_q.dispatch;
  assign vld_nxt_o = ent_d.dispatch;

  // Issue-form view; valid marks a select candidate (both operands held).
  always_comb begin
    iss_o                    = '0;
    iss_o.valid              = ent_q.dispatch && ent_q.op1_ready && ent_q.op2_ready;
    iss_o.thread_ID          = ent_q.thread_ID;
    iss_o.op_type            = ent_q.op_type;
    iss_o.operation          = ent_q.operation;
    iss_o.op1_value          = ent_q.op1_value;
    iss_o.op2_value          = ent_q.op2_value;
    iss_o.dest_PRF_index     = ent_q.dest_PRF_index;
    iss_o.next_pc            = ent_q.next_pc;
    iss_o.branch_target_addr = ent_q.branch_target_addr;
  end

endmodule

// File: rtl/rs_two_wide.sv
// Two-wide reservation station: allocates up to two entries per cycle, wakes
// operands off two CDBs, issues the lowest ready entry, reports full flags.
module rs_two_wide
  import rs_two_wide_pkg::*;
#(
  parameter int RS_SIZE = RS_DEPTH,
  parameter int RS_BITS = $clog2(RS_SIZE)
) (
  input logic          clock,
  input logic          reset,
  rs_two_wide_if.slave bus
);

  localparam logic [RS_BITS:0] CNT_ALL = (RS_BITS+1)'(RS_SIZE);
  localparam logic [RS_BITS:0] CNT_ONE = (RS_BITS+1)'(1);

  logic [1:0]         mis;
  logic               d0, d1;
  logic [RS_SIZE-1:0] vld, vld_nxt, wr_en, wr_sel1, iss_sel;
  RS_ISSUE            pay [RS_SIZE];

  logic               have0, have1;
  logic [RS_BITS-1:0] idx0, idx1;
  logic               win_vld, issue_fire;
  logic [RS_BITS-1:0] win_idx;

  RS_ISSUE            iss_q, iss_d;
  logic [RS_BITS:0]   free_cnt_q, free_cnt_d, n_disp;
  logic               full_q, afull_q;

  assign mis = {bus.mispredict_ROB_1, bus.mispredict_ROB_0};

  // Squashed-thread dispatches never claim an entry.
  assign d0 = bus.disp_RS_0.dispatch && !mis[bus.disp_RS_0.thread_ID];
  assign d1 = bus.disp_RS_1.dispatch && !mis[bus.disp_RS_1.thread_ID];

  // Two lowest entries free at the start of the cycle.
  always_comb begin
    have0 = 1'b0;
    have1 = 1'b0;
    idx0  = '0;
    idx1  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!vld[i]) begin
        if (!have0) begin
          have0 = 1'b1;
          idx0  = RS_BITS'(i);
        end else if (!have1) begin
          have1 = 1'b1;
          idx1  = RS_BITS'(i);
        end
      end
    end
  end

  always_comb begin
    wr_en   = '0;
    wr_sel1 = '0;
    if (d0 && have0)
      wr_en[idx0] = 1'b1;
    if (d1) begin
      if (d0) begin
        if (have1) begin
          wr_en[idx1]   = 1'b1;
          wr_sel1[idx1] = 1'b1;
        end
      end else if (have0) begin
        wr_en[idx0]   = 1'b1;
        wr_sel1[idx0] = 1'b1;
      end
    end
  end

  // Lowest-index ready entry wins select.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (pay[i].valid && !win_vld) begin
        win_vld = 1'b1;
        win_idx = RS_BITS'(i);
      end
    end
  end

  assign issue_fire = win_vld && !bus.issue_stall && !mis[pay[win_idx].thread_ID];

  always_comb begin
    iss_sel          = '0;
    iss_sel[win_idx] = issue_fire;
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    rs_entry u_ent (
      .clock     (clock),
      .reset     (reset),
      .wr_en_i   (wr_en[g]),
      .wr_pkt_i  (wr_sel1[g] ? bus.disp_RS_1 : bus.disp_RS_0),
      .cdb0_i    (bus.cdb_0),
      .cdb1_i    (bus.cdb_1),
      .squash_i  (mis),
      .issue_i   (iss_sel[g]),
      .vld_o     (vld[g]),
      .vld_nxt_o (vld_nxt[g]),
      .iss_o     (pay[g])
    );
  end

  // Under stall the register holds, but a squash still kills a held op.
  always_comb begin
    iss_d = iss_q;
    if (!bus.issue_stall) begin
      iss_d       = pay[win_idx];
      iss_d.valid = issue_fire;
    end
    if (mis[iss_d.thread_ID])
      iss_d.valid = 1'b0;
  end

  always_comb begin
    free_cnt_d = CNT_ALL;
    for (int i = 0; i < RS_SIZE; i++)
      if (vld_nxt[i]) free_cnt_d = free_cnt_d - CNT_ONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iss_q      <= '0;
      free_cnt_q <= CNT_ALL;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      iss_q      <= iss_d;
      free_cnt_q <= free_cnt_d;
      full_q     <= (free_cnt_d == '0);
      afull_q    <= (free_cnt_d == CNT_ONE);
    end
  end

  assign bus.issue_out      = iss_q;
  assign bus.RS_full        = full_q;
  assign bus.RS_almost_full = afull_q;

  assign n_disp = (RS_BITS+1)'(d0) + (RS_BITS+1)'(d1);

  // Dispatch must respect the advertised free count; overflow packets are dropped.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    n_disp <= free_cnt_q);

endmodule

// File: tb/tb_rs_two_wide.sv
// Bench for rs_two_wide: directed scenarios plus random traffic, all checked
// each cycle against a queue/array model of the reservation-station rules.
module tb_rs_two_wide;
  import rs_two_wide_pkg::*;

  localparam int N = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  rs_two_wide_if bus();

  rs_two_wide #(.RS_SIZE(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  typedef struct { bit v; DISPATCH_RS p; } ment_t;
  ment_t   m [N];
  RS_ISSUE m_iss;
  int      m_free;
  bit      m_full, m_af;

  function automatic DISPATCH_RS m_wake(DISPATCH_RS p, CDB_PACKET a, CDB_PACKET b);
    CDB_PACKET c [2];
    c[0] = b;  // applied first so that cdb_0 overrides
    c[1] = a;
    foreach (c[k]) begin
      if (c[k].valid && !p.op1_ready && c[k].PRN == p.op1_PRF_index) p.op1_value = c[k].value;
      if (c[k].valid && !p.op2_ready && c[k].PRN == p.op2_PRF_index) p.op2_value = c[k].value;
    end
    foreach (c[k]) begin
      if (c[k].valid && c[k].PRN == p.op1_PRF_index) p.op1_ready = 1'b1;
      if (c[k].valid && c[k].PRN == p.op2_PRF_index) p.op2_ready = 1'b1;
    end
    return p;
  endfunction

  task automatic mreset();
    foreach (m[i]) m[i].v = 1'b0;
    m_iss  = '0;
    m_free = N;
    m_full = 1'b0;
    m_af   = 1'b0;
  endtask

  task automatic mstep();
    int         fq [$];
    int         win;
    bit [1:0]   mis;
    DISPATCH_RS pk [2];
    mis = {bus.mispredict_ROB_1, bus.mispredict_ROB_0};
    win = -1;
    for (int i = 0; i < N; i++) begin
      if (!m[i].v) fq.push_back(i);
      else if (win < 0 && m[i].p.op1_ready && m[i].p.op2_ready) win = i;
    end
    if (!bus.issue_stall) begin
      m_iss = '0;
      if (win >= 0 && !mis[m[win].p.thread_ID]) begin
        m_iss.valid              = 1'b1;
        m_iss.thread_ID          = m[win].p.thread_ID;
        m_iss.op_type            = m[win].p.op_type;
        m_iss.operation          = m[win].p.operation;
        m_iss.op1_value          = m[win].p.op1_value;
        m_iss.op2_value          = m[win].p.op2_value;
        m_iss.dest_PRF_index     = m[win].p.dest_PRF_index;
        m_iss.next_pc            = m[win].p.next_pc;
        m_iss.branch_target_addr = m[win].p.branch_target_addr;
        m[win].v = 1'b0;
      end
    end
    if (mis[m_iss.thread_ID]) m_iss.valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m[i].v) begin
        m[i].p = m_wake(m[i].p, bus.cdb_0, bus.cdb_1);
        if (mis[m[i].p.thread_ID]) m[i].v = 1'b0;
      end
    end
    pk[0] = bus.disp_RS_0;
    pk[1] = bus.disp_RS_1;
    for (int s = 0; s < 2; s++) begin
      if (pk[s].dispatch && !mis[pk[s].thread_ID] && fq.size() > 0) begin
        int k;
        k = fq.pop_front();
        m[k].v = 1'b1;
        m[k].p = m_wake(pk[s], bus.cdb_0, bus.cdb_1);
      end
    end
    m_free = 0;
    foreach (m[i]) if (!m[i].v) m_free++;
    m_full = (m_free == 0);
    m_af   = (m_free == 1);
  endtask

  always @(posedge clock) if (reset) mstep();
  always @(negedge reset) mreset();

  // ---------------- checking ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("issue_valid", 64'(bus.issue_out.valid), 64'(m_iss.valid));
    if (m_iss.valid) begin
      checks++;
      if (bus.issue_out !== m_iss) begin
        errors++;
        $display("FAIL issue_payload: got %h expected %h", bus.issue_out, m_iss);
      end
    end
    chk("RS_full", 64'(bus.RS_full), 64'(m_full));
    chk("RS_almost_full", 64'(bus.RS_almost_full), 64'(m_af));
  end

  // ---------------- stimulus helpers ----------------
  function automatic DISPATCH_RS mk(bit thr, bit r1, logic [63:0] v1, int p1,
                                    bit r2, logic [63:0] v2, int p2, int dest);
    DISPATCH_RS d;
    d                    = '0;
    d.dispatch           = 1'b1;
    d.thread_ID          = thr;
    d.op_type            = op_type_t'(dest % 5);
    d.operation          = 5'(dest);
    d.op1_ready          = r1;
    d.op1_value          = v1;
    d.op1_PRF_index      = PRF_BITS'(p1);
    d.op2_ready          = r2;
    d.op2_value          = v2;
    d.op2_PRF_index      = PRF_BITS'(p2);
    d.dest_PRF_index     = PRF_BITS'(dest);
    d.next_pc            = 64'h1000 + 64'(dest) * 4;
    d.branch_target_addr = 64'h8000 + 64'(dest);
    return d;
  endfunction

  function automatic CDB_PACKET cdb(bit v, int prn, logic [63:0] val);
    CDB_PACKET c;
    c.valid = v;
    c.PRN   = PRF_BITS'(prn);
    c.value = val;
    return c;
  endfunction

  task automatic idle();
    bus.disp_RS_0        = '0;
    bus.disp_RS_1        = '0;
    bus.cdb_0            = '0;
    bus.cdb_1            = '0;
    bus.mispredict_ROB_0 = 1'b0;
    bus.mispredict_ROB_1 = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic DISPATCH_RS rnd_pkt();
    return mk(1'($urandom), ($urandom % 3) == 0, {$urandom, $urandom}, 32 + $urandom % 12,
              ($urandom % 2) == 0, {$urandom, $urandom}, 32 + $urandom % 12,
              $urandom_range(0, 63));
  endfunction

  int got [$];

  initial begin
    mreset();
    idle();
    bus.issue_stall = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_issue_valid", 64'(bus.issue_out.valid), 64'd0);
    chk("rst_full", 64'(bus.RS_full), 64'd0);
    chk("rst_afull", 64'(bus.RS_almost_full), 64'd0);
    reset = 1'b1;

    // Ready-at-dispatch op issues one edge after allocation.
    bus.disp_RS_0 = mk(0, 1, 64'd5, 0, 1, 64'd7, 0, 20);
    cyc(); idle(); cyc();
    chk("t1_valid", 64'(bus.issue_out.valid), 64'd1);
    chk("t1_op1", bus.issue_out.op1_value, 64'd5);
    chk("t1_op2", bus.issue_out.op2_value, 64'd7);
    chk("t1_dest", 64'(bus.issue_out.dest_PRF_index), 64'd20);
    chk("t1_full", 64'(bus.RS_full), 64'd0);

    // Waits on PRN 33 until cdb_0 supplies it.
    bus.disp_RS_0 = mk(0, 0, 64'd0, 33, 1, 64'd3, 0, 21);
    cyc(); idle(); cyc(); cyc();
    chk("t2_blocked", 64'(bus.issue_out.valid), 64'd0);
    bus.cdb_0 = cdb(1, 33, 64'hDEAD);
    cyc(); idle(); cyc();
    chk("t2_valid", 64'(bus.issue_out.valid), 64'd1);
    chk("t2_op1", bus.issue_out.op1_value, 64'hDEAD);
    chk("t2_dest", 64'(bus.issue_out.dest_PRF_index), 64'd21);

    // Broadcast in the dispatch cycle is not lost.
    bus.disp_RS_0 = mk(0, 0, 64'd0, 40, 1, 64'd4, 0, 22);
    bus.cdb_1     = cdb(1, 40, 64'd9);
    cyc(); idle(); cyc();
    chk("t3_valid", 64'(bus.issue_out.valid), 64'd1);
    chk("t3_op1", bus.issue_out.op1_value, 64'd9);

    // Fill under stall, then drain lowest index first.
    bus.issue_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.disp_RS_0 = mk(0, 1, 64'(k), 0, 1, 64'(k), 0, 100 - 64 + 2 * k);
      bus.disp_RS_1 = mk(1, 1, 64'(k), 0, 1, 64'(k), 0, 101 - 64 + 2 * k);
      cyc();
    end
    idle();
    chk("t4_six_afull", 64'(bus.RS_almost_full), 64'd0);
    bus.disp_RS_0 = mk(0, 1, 64'd6, 0, 1, 64'd6, 0, 106 - 64);
    cyc(); idle();
    chk("t4_seven_afull", 64'(bus.RS_almost_full), 64'd1);
    chk("t4_seven_full", 64'(bus.RS_full), 64'd0);
    bus.disp_RS_0 = mk(1, 1, 64'd7, 0, 1, 64'd7, 0, 107 - 64);
    cyc(); idle();
    chk("t4_eight_full", 64'(bus.RS_full), 64'd1);
    chk("t4_eight_afull", 64'(bus.RS_almost_full), 64'd0);
    bus.issue_stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t4_drain_valid", 64'(bus.issue_out.valid), 64'd1);
      chk("t4_drain_dest", 64'(bus.issue_out.dest_PRF_index), 64'(100 - 64 + k));
      if (k == 0) chk("t4_full_drop", 64'(bus.RS_full), 64'd0);
    end

    // Thread-0 squash with a same-cycle thread-0 dispatch.
    for (int k = 0; k < 3; k++) begin
      bus.disp_RS_0 = mk(0, 0, 64'd0, 50 + k, 1, 64'd1, 0, 10 + k);
      bus.disp_RS_1 = mk(1, 0, 64'd0, 61 + k, 1, 64'd1, 0, 1 + k);
      cyc();
    end
    idle();
    bus.mispredict_ROB_0 = 1'b1;
    bus.disp_RS_0        = mk(0, 1, 64'd1, 0, 1, 64'd1, 0, 77 - 64);
    cyc(); idle();
    chk("t5_free5", 64'(dut.free_cnt_q), 64'd5);
    bus.cdb_0 = cdb(1, 61, 64'h61);
    bus.cdb_1 = cdb(1, 62, 64'h62);
    cyc();
    bus.cdb_0 = cdb(1, 63, 64'h63);
    bus.cdb_1 = '0;
    got.delete();
    for (int k = 0; k < 5; k++) begin
      cyc(); idle();
      if (bus.issue_out.valid) got.push_back(int'(bus.issue_out.dest_PRF_index));
    end
    chk("t5_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("t5_first", 64'(got[0]), 64'd1);
      chk("t5_second", 64'(got[1]), 64'd2);
      chk("t5_third", 64'(got[2]), 64'd3);
    end

    // Asynchronous reset with four live entries and a held issue.
    bus.disp_RS_0 = mk(0, 1, 64'd1, 0, 1, 64'd1, 0, 30);
    bus.disp_RS_1 = mk(1, 1, 64'd1, 0, 1, 64'd1, 0, 31);
    cyc();
    bus.disp_RS_0 = mk(0, 1, 64'd1, 0, 1, 64'd1, 0, 32);
    bus.disp_RS_1 = mk(1, 1, 64'd1, 0, 1, 64'd1, 0, 33);
    cyc(); idle();
    bus.issue_stall = 1'b1;
    bus.disp_RS_0   = mk(0, 1, 64'd1, 0, 1, 64'd1, 0, 34);
    cyc(); idle();
    chk("t6_pre_valid", 64'(bus.issue_out.valid), 64'd1);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (bus.issue_out !== '0) begin
      errors++;
      $display("FAIL t6_async_issue: got %h expected 0", bus.issue_out);
    end
    chk("t6_async_full", 64'(bus.RS_full), 64'd0);
    chk("t6_async_afull", 64'(bus.RS_almost_full), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    bus.issue_stall = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      int nd;
      idle();
      nd = $urandom_range(0, 2);
      if (nd > m_free) nd = m_free;
      if (nd == 2) begin
        bus.disp_RS_0 = rnd_pkt();
        bus.disp_RS_1 = rnd_pkt();
      end else if (nd == 1) begin
        if ($urandom % 2) bus.disp_RS_0 = rnd_pkt();
        else              bus.disp_RS_1 = rnd_pkt();
      end
      if ($urandom % 2) bus.cdb_0 = cdb(1, 32 + $urandom % 12, {$urandom, $urandom});
      if ($urandom % 2) bus.cdb_1 = cdb(1, 32 + $urandom % 12, {$urandom, $urandom});
      bus.mispredict_ROB_0 = ($urandom % 40) == 0;
      bus.mispredict_ROB_1 = ($urandom % 40) == 0;
      bus.issue_stall      = ($urandom % 4) == 0;
      cyc();
    end
    idle();
    bus.issue_stall = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_two_wide.md
Name: rs_two_wide

Overview:
- Reservation station on the receiving end of the dispatch→RS interface.
- Accepts up to two DISPATCH_RS packets per cycle (slot 0, slot 1).
- Holds each packet until both operands are ready, capturing operands from two CDB broadcasts.
- Issues one ready op per cycle to the functional units, and returns RS_full/RS_almost_full to dispatch for its stall logic.

Parameters:
- RS_SIZE, 8, number of entries (≥4).
- RS_BITS, $clog2(RS_SIZE), entry index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low: entries cleared while reset==0.
- disp_RS_0  in  DISPATCH_RS  dispatch slot 0 (dispatch, thread_ID, op_type, operation, op1/op2 ready/value/PRF_index, dest_PRF_index, next_pc, branch_target_addr).
- disp_RS_1  in  DISPATCH_RS  dispatch slot 1, younger than slot 0.
- cdb_0, cdb_1  in  CDB_PACKET  valid, PRN[`PRF_BITS], value[64].
- mispredict_ROB_0  in  1  squash all thread-0 entries.
- mispredict_ROB_1  in  1  squash all thread-1 entries.
- issue_stall  in  1  FU cannot accept; hold issue register.
- issue_out  out  RS_ISSUE  valid, thread_ID, op_type, operation, op1_value, op2_value, dest_PRF_index, next_pc, branch_target_addr.
- RS_full  out  1  free entries == 0.
- RS_almost_full  out  1  free entries == 1.

Behaviour:
Reset
- Reset state: all entries invalid, issue_out.valid=0, RS_full=0, RS_almost_full=0.
- Reset mid-operation discards everything immediately, asynchronously.

Allocation
- On each rising edge, each slot with dispatch=1 writes the lowest-index entry that was free at the start of the cycle.
- Slot 0 gets the lower index; slot 1 gets the next free index.
- Dispatch never targets more entries than are free. If it does (protocol violation), excess packets are dropped and an assertion fires.
- Entries freed by issue in a cycle are not reusable until the next cycle.

Wakeup
- Each cycle, every valid entry with opX_ready=0 whose opX_PRF_index equals a valid CDB PRN sets opX_ready=1 and captures the value.
- The same check applies to packets being dispatched in that cycle, so there is no lost wakeup.
- If both CDBs match the same PRN, cdb_0 takes priority.

Select/issue
- Candidates are valid entries with both operands ready at the start of the cycle; the lowest index wins.
- If issue_stall=0, the winner is copied into issue_out on the edge, its entry is freed, and issue_out.valid=1.
- If there is no winner, issue_out.valid=0.
- If issue_stall=1, issue_out holds its contents and no entry is freed.

Latency
- Dispatch with both operands ready at edge E0 → issue_out.valid at E1 (if selected and unstalled).
- CDB wakeup captured at E0 → issue at E1 at the earliest.

Mispredict
- mispredict_ROB_t invalidates every entry with thread_ID==t at the edge.
- Same-cycle dispatch of a thread-t packet is ignored.
- A thread-t winner is not issued.
- A held issue_out of thread t is cleared (valid=0), even under stall.
- Other-thread entries are unaffected.

Full flags
- Registered, computed from the next-state free count.
- RS_full=1 iff 0 free; RS_almost_full=1 iff exactly 1 free; the two flags are mutually exclusive.

Width rules
- Free count is RS_BITS+1 wide.
- Values are 64-bit, with no sign handling in this block.

Decomposition:
- Shared package: DISPATCH_RS, CDB_PACKET, RS_ISSUE structs; `PRF_BITS, `RS_SIZE; op_type enum.
- One sub-module: rs_entry, holding a single entry with its valid bit, wakeup comparators, squash, and write port.
- The top level contains:
  - free-entry priority encoder (two lowest free);
  - ready-entry priority select;
  - issue register;
  - free counter and full flags.

Test Plan:
- Reset, then dispatch slot0 {op1_ready=1, op1_value=5, op2_ready=1, op2_value=7, dest=20} → next edge issue_out.valid=1, op1_value=5, op2_value=7, dest_PRF_index=20; RS_full=0.
- Dispatch an op with op1_ready=0, op1_PRF_index=33 → never issues. Then cdb_0 {valid, PRN=33, value=64'hDEAD} → issue_out.op1_value=64'hDEAD one edge later.
- Same cycle: dispatch op waiting on PRN 40 while cdb_1 broadcasts PRN 40 value 9 → issues next edge with op1_value=9.
- With issue_stall=1, fill 8 entries two per cycle → RS_almost_full=1 after 7, RS_full=1 after 8. Release stall → one issue per cycle, lowest index first, RS_full drops after the first issue.
- Six entries, three per thread, all unready; mispredict_ROB_0=1 plus a thread-0 dispatch the same cycle → free count rises to 5; thread-1 entries still issue after wakeup; the thread-0 dispatch is absent.
- Assert reset (0) mid-stream with 4 valid entries and issue_out valid → all outputs 0 immediately, before the next clock edge.
